// File: rtl/irda_fir_rx_datapath.sv
// IrDA FIR receive datapath: chip bit-sync, 4PPM decoder, serial CRC-32.
// Single clock domain; symbol alignment is established by rx_restart.
`timescale 1ns/1ps
module irda_fir_rx_datapath #(
    parameter int          SAMPLES_PER_CHIP = 4,
    parameter logic [31:0] CRC_POLY         = 32'h04C11DB7,
    parameter logic [31:0] CRC_RESIDUE      = 32'hC704DD7B
) (
    input  logic        clk,
    input  logic        wb_rst_i,
    input  logic        fast_enable,
    input  logic        fir_rx8_enable,
    input  logic        fir_rx4_enable,
    input  logic        rx_restart,
    input  logic        rx_i,
    input  logic        clrcrc,
    input  logic        crc_en,
    output logic        bs_o,
    output logic        ppmd_o,
    output logic        ppmd_bad_chip,
    output logic [31:0] crc32_par_o,
    output logic        crc_ok
);

    localparam int PW = $clog2(SAMPLES_PER_CHIP);
    localparam logic [PW-1:0] HALF = PW'(SAMPLES_PER_CHIP / 2);
    localparam logic [PW-1:0] LAST = PW'(SAMPLES_PER_CHIP - 1);
    localparam logic [PW-1:0] ONE  = PW'(1);

    logic          rx_meta;
    logic          rx_sync;
    logic          rx_prev;
    logic [PW-1:0] phase;

    logic [3:0] chips;
    logic [3:0] sym_next;
    logic [1:0] chip_cnt;
    logic [1:0] pair_q;
    logic [1:0] dec_pair;
    logic       dec_ok;
    logic       valid;
    logic       sel;
    logic       fb;

    // An edge restarts the phase so the sample lands mid-chip
    always_ff @(posedge clk) begin
        if (wb_rst_i) begin
            rx_meta <= 1'b0;
            rx_sync <= 1'b0;
            rx_prev <= 1'b0;
            phase   <= '0;
            bs_o    <= 1'b0;
        end else begin
            rx_meta <= rx_i;
            rx_sync <= rx_meta;
            if (rx_restart) begin
                phase <= '0;
                bs_o  <= 1'b0;
            end else if (fast_enable) begin
                rx_prev <= rx_sync;
                if (rx_sync != rx_prev)
                    phase <= ONE;
                else if (phase == LAST)
                    phase <= '0;
                else
                    phase <= phase + ONE;
                if (phase == HALF)
                    bs_o <= rx_sync;
            end
        end
    end

    // First received chip ends up in bit 0
    assign sym_next = {bs_o, chips[3:1]};

    always_comb begin
        dec_pair = 2'd0;
        dec_ok   = 1'b1;
        case (sym_next)
            4'b0001: dec_pair = 2'd0;
            4'b0010: dec_pair = 2'd1;
            4'b0100: dec_pair = 2'd2;
            4'b1000: dec_pair = 2'd3;
            default: dec_ok   = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wb_rst_i || rx_restart) begin
            chips         <= 4'd0;
            chip_cnt      <= 2'd0;
            valid         <= 1'b0;
            sel           <= 1'b0;
            ppmd_o        <= 1'b0;
            ppmd_bad_chip <= 1'b0;
            if (wb_rst_i)
                pair_q <= 2'd0;
        end else begin
            if (fir_rx4_enable) begin
                ppmd_o <= valid ? pair_q[sel] : 1'b0;
                sel    <= ~sel;
            end
            if (fir_rx8_enable) begin
                chips    <= sym_next;
                chip_cnt <= chip_cnt + 2'd1;
                if (chip_cnt == 2'd3) begin
                    pair_q <= dec_ok ? dec_pair : 2'd0;
                    valid  <= 1'b1;
                    sel    <= 1'b0;
                    if (!dec_ok)
                        ppmd_bad_chip <= 1'b1;
                end
            end
        end
    end

    // CRC consumes ppmd_o as it stands before this strobe updates it
    assign fb = crc32_par_o[31] ^ ppmd_o;

    always_ff @(posedge clk) begin
        if (wb_rst_i || clrcrc)
            crc32_par_o <= 32'hFFFFFFFF;
        else if (fir_rx4_enable && crc_en)
            crc32_par_o <= {crc32_par_o[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0);
    end

    assign crc_ok = (crc32_par_o == CRC_RESIDUE);

endmodule

// File: tb/tb_irda_fir_rx_datapath.sv
// Scoreboard bench for irda_fir_rx_datapath: timed expectations are queued
// by the stimulus and retired by a negedge monitor.
`timescale 1ns/1ps
module tb_irda_fir_rx_datapath;

    localparam int K_PPMD = 0;
    localparam int K_BAD  = 1;
    localparam int K_CRC  = 2;
    localparam int K_OK   = 3;
    localparam int K_BS   = 4;

    logic        clk = 1'b0;
    logic        wb_rst_i;
    logic        fast_enable;
    logic        fir_rx8_enable;
    logic        fir_rx4_enable;
    logic        rx_restart;
    logic        rx_i;
    logic        clrcrc;
    logic        crc_en;
    logic        bs_o;
    logic        ppmd_o;
    logic        ppmd_bad_chip;
    logic [31:0] crc32_par_o;
    logic        crc_ok;

    int cyc      = 0;
    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          at;
        int          kind;
        logic [31:0] val;
    } exp_t;

    exp_t sbq[$];
    logic chipq[$];
    logic expq[$];

    always #5 clk = ~clk;

    irda_fir_rx_datapath dut (
        .clk            (clk),
        .wb_rst_i       (wb_rst_i),
        .fast_enable    (fast_enable),
        .fir_rx8_enable (fir_rx8_enable),
        .fir_rx4_enable (fir_rx4_enable),
        .rx_restart     (rx_restart),
        .rx_i           (rx_i),
        .clrcrc         (clrcrc),
        .crc_en         (crc_en),
        .bs_o           (bs_o),
        .ppmd_o         (ppmd_o),
        .ppmd_bad_chip  (ppmd_bad_chip),
        .crc32_par_o    (crc32_par_o),
        .crc_ok         (crc_ok)
    );

    // Strobes: fast every 2 clk, chip every 8 clk, bit every 16 clk
    initial begin
        fast_enable    = 1'b0;
        fir_rx8_enable = 1'b0;
        fir_rx4_enable = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            fast_enable    = (cyc % 2 == 1);
            fir_rx8_enable = (cyc % 8 == 1);
            fir_rx4_enable = (cyc % 16 == 1);
        end
    end

    function automatic logic [31:0] observe(input int kind);
        case (kind)
            K_PPMD:  return {31'd0, ppmd_o};
            K_BAD:   return {31'd0, ppmd_bad_chip};
            K_CRC:   return crc32_par_o;
            K_OK:    return {31'd0, crc_ok};
            default: return {31'd0, bs_o};
        endcase
    endfunction

    function automatic string kname(input int kind);
        case (kind)
            K_PPMD:  return "ppmd_o";
            K_BAD:   return "ppmd_bad_chip";
            K_CRC:   return "crc32_par_o";
            K_OK:    return "crc_ok";
            default: return "bs_o";
        endcase
    endfunction

    always @(negedge clk) begin
        for (int i = sbq.size() - 1; i >= 0; i--) begin
            if (sbq[i].at <= cyc) begin
                checks++;
                if (sbq[i].at != cyc || observe(sbq[i].kind) !== sbq[i].val) begin
                    failures++;
                    $display("FAIL %s @cyc %0d: got %h, expected %h",
                             kname(sbq[i].kind), sbq[i].at,
                             observe(sbq[i].kind), sbq[i].val);
                end
                sbq.delete(i);
            end
        end
    end

    task automatic expect_at(input int at, input int kind, input logic [31:0] v);
        exp_t e;
        e.at   = at;
        e.kind = kind;
        e.val  = v;
        sbq.push_back(e);
    endtask

    task automatic at_cyc(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send_chip(input logic b, input bit jit, input bit chk);
        int m;
        do begin
            @(posedge clk);
            #2;
        end while (cyc % 8 != 0);
        m = cyc / 8;
        if (jit) begin
            @(posedge clk);
            #2;
        end
        rx_i = b;
        if (chk)
            expect_at(8 * m + 12, K_BS, {31'd0, b});
    endtask

    task automatic add_chips(input logic [3:0] c);
        for (int j = 3; j >= 0; j--)
            chipq.push_back(c[j]);
    endtask

    task automatic add_bits(input logic b0, input logic b1);
        int k;
        expq.push_back(b0);
        expq.push_back(b1);
        k = int'(b0) + 2 * int'(b1);
        for (int j = 0; j < 4; j++)
            chipq.push_back(j == k);
    endtask

    task automatic crc_script(input int mode, input int p0, input int nb);
        if (mode == 5) begin
            at_cyc(p0 - 17); clrcrc = 1'b1;
            at_cyc(p0 - 16); clrcrc = 1'b0;
            at_cyc(p0 - 1);  crc_en = 1'b1;
            at_cyc(p0);      crc_en = 1'b0;
            at_cyc(p0 + 7);  clrcrc = 1'b1;
            at_cyc(p0 + 8);  clrcrc = 1'b0;
            at_cyc(p0 + 15); crc_en = 1'b1;
            at_cyc(p0 + 16); crc_en = 1'b0;
            at_cyc(p0 + 47); clrcrc = 1'b1; crc_en = 1'b1;
            at_cyc(p0 + 48); clrcrc = 1'b0; crc_en = 1'b0;
        end else if (mode >= 6) begin
            at_cyc(p0 - 1);  clrcrc = 1'b1; crc_en = 1'b1;
            at_cyc(p0);      clrcrc = 1'b0;
            at_cyc(p0 + 16 * nb + 1); crc_en = 1'b0;
        end
    endtask

    // First chip, restart, remaining chips, then idle chips
    task automatic run_frame(input int mode, input logic bad_final);
        int r, l0, p0, n, ll, nb;
        n  = chipq.size() / 4;
        nb = expq.size();
        send_chip(chipq.pop_front(), 1'b0, 1'b0);
        r  = cyc / 8;
        l0 = 8 * r + 34;
        ll = l0 + 32 * (n - 1);
        p0 = l0 + 1;
        while (p0 % 16 != 2)
            p0++;
        for (int i = 0; i < nb; i++)
            expect_at(p0 + 16 * i, K_PPMD, {31'd0, expq[i]});
        expect_at(l0 - 1, K_BAD, 32'd0);
        expect_at(ll, K_BAD, {31'd0, bad_final});
        if (bad_final)
            expect_at(ll + 64, K_BAD, 32'd1);
        if (mode == 5) begin
            expect_at(p0 + 1,  K_CRC, 32'hFB3EE249);
            expect_at(p0 + 9,  K_CRC, 32'hFFFFFFFF);
            expect_at(p0 + 17, K_CRC, 32'hFFFFFFFE);
            expect_at(p0 + 33, K_CRC, 32'hFFFFFFFE);
            expect_at(p0 + 33, K_OK,  32'd0);
            expect_at(p0 + 49, K_CRC, 32'hFFFFFFFF);
        end else if (mode == 6) begin
            expect_at(p0 + 16 * nb + 2, K_CRC, 32'hC704DD7B);
            expect_at(p0 + 16 * nb + 2, K_OK,  32'd1);
        end else if (mode == 7) begin
            expect_at(p0 + 16 * nb + 2, K_OK,  32'd0);
        end
        fork
            crc_script(mode, p0, nb);
        join_none
        at_cyc(8 * r + 1); rx_restart = 1'b1;
        at_cyc(8 * r + 2); rx_restart = 1'b0;
        while (chipq.size() > 0)
            send_chip(chipq.pop_front(), 1'b0, 1'b0);
        repeat (16)
            send_chip(1'b0, 1'b0, 1'b0);
        expq.delete();
    endtask

    task automatic load_msg(input bit flip);
        logic [7:0] msg [13];
        logic [7:0] b;
        logic       bits[$];
        msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
                8'h38, 8'h39, 8'hFC, 8'h89, 8'h19, 8'h18};
        for (int i = 0; i < 13; i++) begin
            b = msg[i];
            if (flip && i == 4)
                b[2] = ~b[2];
            for (int j = 7; j >= 0; j--)
                bits.push_back(b[j]);
        end
        for (int i = 0; i < bits.size(); i += 2)
            add_bits(bits[i], bits[i + 1]);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        wb_rst_i   = 1'b1;
        rx_i       = 1'b0;
        rx_restart = 1'b0;
        clrcrc     = 1'b0;
        crc_en     = 1'b0;

        at_cyc(3);
        expect_at(4, K_BS,   32'd0);
        expect_at(4, K_PPMD, 32'd0);
        expect_at(4, K_BAD,  32'd0);
        expect_at(4, K_CRC,  32'hFFFFFFFF);
        expect_at(4, K_OK,   32'd0);
        at_cyc(6);
        wb_rst_i = 1'b0;

        send_chip(1'b0, 1'b0, 1'b0);
        send_chip(1'b0, 1'b0, 1'b0);
        send_chip(1'b1, 1'b0, 1'b1);
        send_chip(1'b0, 1'b0, 1'b1);
        send_chip(1'b1, 1'b1, 1'b1);
        send_chip(1'b1, 1'b0, 1'b1);
        send_chip(1'b0, 1'b0, 1'b0);

        add_chips(4'b0100);
        add_chips(4'b0001);
        add_chips(4'b1000);
        add_chips(4'b0010);
        expq = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        run_frame(0, 1'b0);

        add_chips(4'b0110);
        expq = '{1'b0, 1'b0};
        run_frame(0, 1'b1);

        add_chips(4'b0000);
        expq = '{1'b0, 1'b0};
        run_frame(0, 1'b1);

        add_chips(4'b0100);
        expq = '{1'b1, 1'b0};
        run_frame(5, 1'b0);

        load_msg(1'b0);
        run_frame(6, 1'b0);

        load_msg(1'b1);
        run_frame(7, 1'b0);

        w = 0;
        while (sbq.size() > 0 && w < 4000) begin
            @(posedge clk);
            w++;
        end
        if (sbq.size() > 0) begin
            checks   += sbq.size();
            failures += sbq.size();
            $display("FAIL scoreboard: %0d expected responses never observed, required 0",
                     sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
